adc_dac_serial_io: RTL and testbench

- Converter-side serial interface that feeds the ADC/DAC sine frontend.
- Once per frame it does three things:
  - shifts the frontend's signed DAC sample out to an SPI-style DAC;
  - shifts in one sample from an SPI-style ADC over a shared SCLK/CS_N;
  - presents the ADC sample as signed data with a one-clock valid strobe.
- The valid strobe is the frontend's pipeline CE, so the frontend advances exactly once per converter sample.

---
 rtl/adc_dac_serial_io_pkg.sv | 32 +++
 rtl/adc_dac_frame_timer.sv | 96 +++++++++
 rtl/adc_dac_serial_io.sv | 112 +++++++++++
 tb/tb_adc_dac_serial_io.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_dac_serial_io_pkg.sv
// Shared types, constants and helpers for the converter-side serial interface.
// Frame timing counts are functions of FRAME_BITS and SCLK_DIV so every instance derives its own.
package adc_dac_serial_io_pkg;

    localparam logic SCLK_IDLE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } frame_state_t;

    // Frame count at which CS_N returns high (first count after the last bit).
    function automatic int cs_rise_count(input int frame_bits, input int sclk_div);
        return 2 * sclk_div * frame_bits + 1;
    endfunction

    // Frame count carrying the ADC_VALUE_VALID strobe.
    function automatic int valid_count(input int frame_bits, input int sclk_div);
        return cs_rise_count(frame_bits, sclk_div) + 1;
    endfunction

    function automatic int min_frame_period(input int frame_bits, input int sclk_div);
        return 2 * sclk_div * frame_bits + 4;
    endfunction

    // Offset binary <-> two's complement is the same MSB inversion in both directions.
    function automatic logic [31:0] flip_msb(input logic [31:0] value, input int width);
        return value ^ (32'd1 << (width - 1));
    endfunction

endpackage

// File: rtl/adc_dac_frame_timer.sv
// Frame sequencer: frame counter, bit index and SCLK phase.
// Strokes are decoded from the next-state values so the registered outputs line up with the counter.
module adc_dac_frame_timer
    import adc_dac_serial_io_pkg::*;
#(
    parameter int FRAME_BITS   = 16,
    parameter int SCLK_DIV     = 2,
    parameter int FRAME_PERIOD = 80
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic load,
    output logic sclk_low,
    output logic sample,
    output logic shift,
    output logic cs_low,
    output logic valid
);

    localparam int CW = $clog2(FRAME_PERIOD);
    localparam int PW = $clog2(2 * SCLK_DIV);
    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam logic [CW-1:0] LAST_CNT   = CW'(FRAME_PERIOD - 1);
    localparam logic [CW-1:0] CS_RISE    = CW'(cs_rise_count(FRAME_BITS, SCLK_DIV));
    localparam logic [CW-1:0] VALID_CNT  = CW'(valid_count(FRAME_BITS, SCLK_DIV));
    localparam logic [PW-1:0] PHASE_LAST = PW'(2 * SCLK_DIV - 1);
    localparam logic [PW-1:0] HALF       = PW'(SCLK_DIV);

    frame_state_t  state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [PW-1:0] phase_reg, phase_next;
    logic [BW-1:0] bit_reg, bit_next;
    logic          in_frame, in_bits;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            phase_reg <= '0;
            bit_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            phase_reg <= phase_next;
            bit_reg   <= bit_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        phase_next = phase_reg;
        bit_next   = bit_reg;
        case (state_reg)
            ST_IDLE: begin
                cnt_next   = '0;
                phase_next = '0;
                bit_next   = '0;
                if (enable) state_next = ST_SHIFT;
            end
            default: begin
                if (cnt_reg == LAST_CNT) begin
                    cnt_next   = '0;
                    phase_next = '0;
                    bit_next   = '0;
                    state_next = enable ? ST_SHIFT : ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                    // Count 0 is the load slot; bit timing starts at count 1.
                    if (cnt_reg != '0) begin
                        if (phase_reg == PHASE_LAST) begin
                            phase_next = '0;
                            bit_next   = bit_reg + 1'b1;
                        end else begin
                            phase_next = phase_reg + 1'b1;
                        end
                    end
                    state_next = (cnt_next < CS_RISE) ? ST_SHIFT : ST_DONE;
                end
            end
        endcase
    end

    always_comb begin
        in_frame = (state_next != ST_IDLE);
        in_bits  = (state_next == ST_SHIFT) && (cnt_next != '0);
        load     = in_frame && (cnt_next == '0);
        cs_low   = (state_next == ST_SHIFT);
        sclk_low = in_bits && (phase_next < HALF);
        sample   = in_bits && (phase_next == HALF);
        shift    = in_bits && (phase_next == '0) && (bit_next != '0);
        valid    = in_frame && (cnt_next == VALID_CNT);
    end

endmodule

// File: rtl/adc_dac_serial_io.sv
// SPI-style converter interface: one DAC word out and one ADC word in per frame over shared SCLK/CS_N.
// ADC_VALUE_VALID doubles as the frontend pipeline CE.
module adc_dac_serial_io
    import adc_dac_serial_io_pkg::*;
#(
    parameter int ADC_DATA_WIDTH   = 12,
    parameter int DAC_DATA_WIDTH   = 12,
    parameter int FRAME_BITS       = 16,
    parameter int SCLK_DIV         = 2,
    parameter int FRAME_PERIOD     = 80,
    parameter int ADC_LEADING_BITS = 4,
    parameter int DAC_LEADING_BITS = 2
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      ENABLE,
    input  logic [DAC_DATA_WIDTH-1:0] DAC_VALUE,
    output logic [ADC_DATA_WIDTH-1:0] ADC_VALUE,
    output logic                      ADC_VALUE_VALID,
    output logic                      SCLK,
    output logic                      CS_N,
    output logic                      DAC_SDO,
    input  logic                      ADC_SDI
);

    generate
        if (SCLK_DIV < 1) begin : g_bad_div
            $error("SCLK_DIV must be at least 1");
        end
        if (FRAME_PERIOD < min_frame_period(FRAME_BITS, SCLK_DIV)) begin : g_bad_period
            $error("FRAME_PERIOD too short for FRAME_BITS and SCLK_DIV");
        end
        if (FRAME_BITS < DAC_LEADING_BITS + DAC_DATA_WIDTH) begin : g_bad_dac
            $error("DAC word does not fit in the frame");
        end
        if (FRAME_BITS < ADC_LEADING_BITS + ADC_DATA_WIDTH) begin : g_bad_adc
            $error("ADC word does not fit in the frame");
        end
    endgenerate

    localparam int DAC_PAD = FRAME_BITS - DAC_LEADING_BITS - DAC_DATA_WIDTH;
    // Leading ADC bits are never stored: they shift out of the top before the frame ends.
    localparam int ASR_W   = FRAME_BITS - ADC_LEADING_BITS;

    logic load, sclk_low, sample, shift, cs_low, valid;

    logic [DAC_DATA_WIDTH-1:0] dac_offset;
    logic [FRAME_BITS-1:0]     dac_word;
    logic [ADC_DATA_WIDTH-1:0] adc_word;
    logic [ADC_DATA_WIDTH-1:0] adc_signed;

    logic                      cs_n_reg;
    logic                      sclk_reg;
    logic [FRAME_BITS-1:0]     dac_sr_reg;
    logic [ASR_W-1:0]          adc_sr_reg;
    logic [ADC_DATA_WIDTH-1:0] adc_value_reg;
    logic                      adc_valid_reg;

    adc_dac_frame_timer #(
        .FRAME_BITS  (FRAME_BITS),
        .SCLK_DIV    (SCLK_DIV),
        .FRAME_PERIOD(FRAME_PERIOD)
    ) u_timer (
        .clk     (CLK),
        .rst     (RESET),
        .enable  (ENABLE),
        .load    (load),
        .sclk_low(sclk_low),
        .sample  (sample),
        .shift   (shift),
        .cs_low  (cs_low),
        .valid   (valid)
    );

    assign dac_offset = DAC_DATA_WIDTH'(flip_msb(32'(DAC_VALUE), DAC_DATA_WIDTH));
    assign dac_word   = FRAME_BITS'(dac_offset) << DAC_PAD;
    assign adc_word   = adc_sr_reg[ASR_W-1 -: ADC_DATA_WIDTH];
    assign adc_signed = ADC_DATA_WIDTH'(flip_msb(32'(adc_word), ADC_DATA_WIDTH));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cs_n_reg      <= 1'b1;
            sclk_reg      <= SCLK_IDLE;
            dac_sr_reg    <= '0;
            adc_sr_reg    <= '0;
            adc_value_reg <= '0;
            adc_valid_reg <= 1'b0;
        end else begin
            cs_n_reg <= ~cs_low;
            sclk_reg <= sclk_low ? ~SCLK_IDLE : SCLK_IDLE;
            // DAC_SDO is the shift register MSB; clearing outside CS keeps the line low between frames.
            if (load)
                dac_sr_reg <= dac_word;
            else if (shift)
                dac_sr_reg <= dac_sr_reg << 1;
            else if (!cs_low)
                dac_sr_reg <= '0;
            if (sample)
                adc_sr_reg <= {adc_sr_reg[ASR_W-2:0], ADC_SDI};
            if (valid)
                adc_value_reg <= adc_signed;
            adc_valid_reg <= valid;
        end
    end

    assign CS_N            = cs_n_reg;
    assign SCLK            = sclk_reg;
    assign DAC_SDO         = dac_sr_reg[FRAME_BITS-1];
    assign ADC_VALUE       = adc_value_reg;
    assign ADC_VALUE_VALID = adc_valid_reg;

endmodule

// File: tb/tb_adc_dac_serial_io.sv
// Self-checking bench: records every port each cycle, models the ADC device, and checks whole
// frames against patterns computed from the frame rules with plain arithmetic.
module tb_adc_dac_serial_io;

    localparam int AW  = 12;
    localparam int DW  = 12;
    localparam int FB  = 16;
    localparam int D   = 2;
    localparam int FP  = 80;
    localparam int ALB = 4;
    localparam int DLB = 2;
    localparam int TRACE_LEN = 8192;
    localparam int VALID_N   = 2 * D * FB + 2;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          ENABLE;
    logic [DW-1:0] DAC_VALUE = '0;
    logic [AW-1:0] ADC_VALUE;
    logic          ADC_VALUE_VALID;
    logic          SCLK;
    logic          CS_N;
    logic          DAC_SDO;
    logic          ADC_SDI = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic          cs_tr   [TRACE_LEN];
    logic          sclk_tr [TRACE_LEN];
    logic          sdo_tr  [TRACE_LEN];
    logic          vld_tr  [TRACE_LEN];
    logic [AW-1:0] adcv_tr [TRACE_LEN];

    logic [FB-1:0] adc_q[$];
    logic [FB-1:0] adc_cur = '0;
    int            adc_idx = 0;
    logic          prev_cs = 1'b1;
    logic          prev_sclk = 1'b1;

    always #5 CLK = ~CLK;

    adc_dac_serial_io #(
        .ADC_DATA_WIDTH(AW), .DAC_DATA_WIDTH(DW), .FRAME_BITS(FB), .SCLK_DIV(D),
        .FRAME_PERIOD(FP), .ADC_LEADING_BITS(ALB), .DAC_LEADING_BITS(DLB)
    ) dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .DAC_VALUE(DAC_VALUE),
        .ADC_VALUE(ADC_VALUE), .ADC_VALUE_VALID(ADC_VALUE_VALID), .SCLK(SCLK),
        .CS_N(CS_N), .DAC_SDO(DAC_SDO), .ADC_SDI(ADC_SDI)
    );

    // Port recorder plus ADC device model: the ADC presents its next bit when SCLK falls.
    always @(negedge CLK) begin
        if (cyc < TRACE_LEN) begin
            cs_tr[cyc]   = CS_N;
            sclk_tr[cyc] = SCLK;
            sdo_tr[cyc]  = DAC_SDO;
            vld_tr[cyc]  = ADC_VALUE_VALID;
            adcv_tr[cyc] = ADC_VALUE;
        end
        if (prev_cs === 1'b1 && CS_N === 1'b0) begin
            adc_cur = (adc_q.size() > 0) ? adc_q.pop_front() : '0;
            adc_idx = 0;
        end
        if (prev_sclk === 1'b1 && SCLK === 1'b0 && CS_N === 1'b0 && adc_idx < FB) begin
            ADC_SDI = adc_cur[FB-1-adc_idx];
            adc_idx++;
        end
        prev_cs   = CS_N;
        prev_sclk = SCLK;
        cyc++;
    end

    initial begin
        #(20000 * 10);
        $display("FAIL watchdog: simulation did not finish within 20000 cycles");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [FP-1:0] model_cs();
        logic [FP-1:0] v;
        for (int i = 0; i < FP; i++) v[i] = (i > 2 * D * FB);
        return v;
    endfunction

    function automatic logic [FP-1:0] model_sclk();
        logic [FP-1:0] v;
        for (int i = 0; i < FP; i++) begin
            if (i >= 1 && i <= 2 * D * FB) v[i] = (((i - 1) % (2 * D)) >= D);
            else                            v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [FP-1:0] model_valid();
        logic [FP-1:0] v;
        for (int i = 0; i < FP; i++) v[i] = (i == VALID_N);
        return v;
    endfunction

    function automatic logic [FB-1:0] model_dac_bits(input logic [DW-1:0] d);
        int val;
        int code;
        val  = $signed(d);
        code = (val + (1 << (DW - 1))) & ((1 << DW) - 1);
        return FB'(code << (FB - DLB - DW));
    endfunction

    function automatic logic [AW-1:0] model_adc(input logic [FB-1:0] w);
        int code;
        code = (int'(w) >> (FB - ALB - AW)) & ((1 << AW) - 1);
        return AW'(code - (1 << (AW - 1)));
    endfunction

    // ---------------- trace observation ----------------
    function automatic int find_fall(input int from);
        for (int c = (from < 1 ? 1 : from); c < cyc && c < TRACE_LEN; c++)
            if (cs_tr[c-1] === 1'b1 && cs_tr[c] === 1'b0) return c;
        return -1;
    endfunction

    function automatic logic [FP-1:0] obs_vec(input int s, input int which);
        logic [FP-1:0] v;
        v = 'x;
        if (s < 0 || s + FP >= TRACE_LEN) return v;
        for (int i = 0; i < FP; i++)
            v[i] = (which == 0) ? cs_tr[s+i] : (which == 1) ? sclk_tr[s+i] : vld_tr[s+i];
        return v;
    endfunction

    // A bit reads as X unless DAC_SDO holds it for the whole bit period.
    function automatic logic [FB-1:0] obs_dac(input int s);
        logic [FB-1:0] v;
        int first;
        logic b;
        v = 'x;
        if (s < 0 || s + FP >= TRACE_LEN) return v;
        for (int k = 0; k < FB; k++) begin
            first = s + 1 + 2 * D * k;
            b = sdo_tr[first];
            for (int c = first + 1; c < first + 2 * D; c++)
                if (sdo_tr[c] !== b) b = 1'bx;
            v[FB-1-k] = b;
        end
        return v;
    endfunction

    function automatic logic [AW-1:0] obs_adc(input int s);
        if (s < 0 || s + VALID_N >= TRACE_LEN) return 'x;
        return adcv_tr[s+VALID_N];
    endfunction

    task automatic wait_cs(input logic level, input int budget, input string what);
        int n;
        n = 0;
        while (CS_N !== level && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (CS_N !== level) begin
            total++; bad++;
            $display("FAIL %s timeout: CS_N=%b after %0d cycles, required %b", what, CS_N, n, level);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RESET = 1'b1;
        ENABLE = 1'b1;
        DAC_VALUE = 12'h800;
        repeat (4) @(negedge CLK);
        total++; if (CS_N !== 1'b1) begin bad++; $display("FAIL reset_cs_n: got %b expected 1", CS_N); end
        total++; if (SCLK !== 1'b1) begin bad++; $display("FAIL reset_sclk: got %b expected 1", SCLK); end
        total++; if (DAC_SDO !== 1'b0) begin bad++; $display("FAIL reset_dac_sdo: got %b expected 0", DAC_SDO); end
        total++; if (ADC_VALUE !== '0) begin bad++; $display("FAIL reset_adc_value: got %h expected 000", ADC_VALUE); end
        total++; if (ADC_VALUE_VALID !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", ADC_VALUE_VALID); end
    endtask

    task automatic test_first_frame();
        int mark, s1, s2;
        adc_q.push_back(16'h0800);
        mark = cyc;
        RESET = 1'b0;
        wait_cs(1'b0, 10, "first_frame_start");
        repeat (FP + 8) @(negedge CLK);
        s1 = find_fall(mark - 2);
        s2 = (s1 < 0) ? -1 : find_fall(s1 + 1);
        total++; if (obs_vec(s1, 0) !== model_cs()) begin bad++; $display("FAIL first_cs_n: got %h expected %h", obs_vec(s1, 0), model_cs()); end
        total++; if (obs_vec(s1, 1) !== model_sclk()) begin bad++; $display("FAIL first_sclk: got %h expected %h", obs_vec(s1, 1), model_sclk()); end
        total++; if (obs_vec(s1, 2) !== model_valid()) begin bad++; $display("FAIL first_valid: got %h expected %h", obs_vec(s1, 2), model_valid()); end
        total++; if (obs_dac(s1) !== model_dac_bits(12'h800)) begin bad++; $display("FAIL first_dac_bits: got %h expected %h", obs_dac(s1), model_dac_bits(12'h800)); end
        total++; if (obs_adc(s1) !== model_adc(16'h0800)) begin bad++; $display("FAIL first_adc_value: got %h expected %h", obs_adc(s1), model_adc(16'h0800)); end
        total++; if (s2 - s1 !== FP) begin bad++; $display("FAIL first_period: got %0d expected %0d", s2 - s1, FP); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] dv[8];
        logic [FB-1:0] aw[8];
        int mark[8];
        int fs[8];
        dv[0] = 12'h7FF; aw[0] = 16'h0000;
        dv[1] = 12'h800; aw[1] = 16'h0FFF;
        for (int j = 2; j < 8; j++) begin
            dv[j] = DW'($urandom);
            aw[j] = FB'($urandom);
        end
        for (int j = 0; j < 8; j++) begin
            wait_cs(1'b1, 2 * FP, "b2b_cs_rise");
            mark[j] = cyc;
            DAC_VALUE = dv[j];
            adc_q.push_back(aw[j]);
            wait_cs(1'b0, 2 * FP, "b2b_cs_fall");
        end
        repeat (FP + 4) @(negedge CLK);
        for (int j = 0; j < 8; j++) begin
            fs[j] = find_fall(mark[j]);
            total++; if (obs_vec(fs[j], 0) !== model_cs()) begin bad++; $display("FAIL b2b_cs_n[%0d]: got %h expected %h", j, obs_vec(fs[j], 0), model_cs()); end
            total++; if (obs_vec(fs[j], 1) !== model_sclk()) begin bad++; $display("FAIL b2b_sclk[%0d]: got %h expected %h", j, obs_vec(fs[j], 1), model_sclk()); end
            total++; if (obs_vec(fs[j], 2) !== model_valid()) begin bad++; $display("FAIL b2b_valid[%0d]: got %h expected %h", j, obs_vec(fs[j], 2), model_valid()); end
            total++; if (obs_dac(fs[j]) !== model_dac_bits(dv[j])) begin bad++; $display("FAIL b2b_dac_bits[%0d]: got %h expected %h (DAC_VALUE %h)", j, obs_dac(fs[j]), model_dac_bits(dv[j]), dv[j]); end
            total++; if (obs_adc(fs[j]) !== model_adc(aw[j])) begin bad++; $display("FAIL b2b_adc_value[%0d]: got %h expected %h (ADC bits %h)", j, obs_adc(fs[j]), model_adc(aw[j]), aw[j]); end
            if (j > 0) begin
                total++; if (fs[j] - fs[j-1] !== FP) begin bad++; $display("FAIL b2b_period[%0d]: got %0d expected %0d", j, fs[j] - fs[j-1], FP); end
            end
        end
    endtask

    task automatic test_dac_change();
        int mark, s1, s2;
        logic [FB-1:0] w1, w2;
        w1 = FB'($urandom);
        w2 = FB'($urandom);
        wait_cs(1'b1, 2 * FP, "dac_change_rise");
        mark = cyc;
        DAC_VALUE = DW'(100);
        adc_q.push_back(w1);
        wait_cs(1'b0, 2 * FP, "dac_change_fall");
        repeat (10) @(negedge CLK);
        DAC_VALUE = DW'(-100);
        adc_q.push_back(w2);
        wait_cs(1'b1, 2 * FP, "dac_change_rise2");
        wait_cs(1'b0, 2 * FP, "dac_change_fall2");
        repeat (FP + 4) @(negedge CLK);
        s1 = find_fall(mark);
        s2 = (s1 < 0) ? -1 : find_fall(s1 + 1);
        total++; if (obs_dac(s1) !== model_dac_bits(DW'(100))) begin bad++; $display("FAIL dac_hold_frame: got %h expected %h", obs_dac(s1), model_dac_bits(DW'(100))); end
        total++; if (obs_dac(s2) !== model_dac_bits(DW'(-100))) begin bad++; $display("FAIL dac_next_frame: got %h expected %h", obs_dac(s2), model_dac_bits(DW'(-100))); end
        total++; if (obs_adc(s1) !== model_adc(w1)) begin bad++; $display("FAIL dac_change_adc1: got %h expected %h", obs_adc(s1), model_adc(w1)); end
        total++; if (obs_adc(s2) !== model_adc(w2)) begin bad++; $display("FAIL dac_change_adc2: got %h expected %h", obs_adc(s2), model_adc(w2)); end
    endtask

    task automatic test_enable_drop();
        int mark, s, later;
        wait_cs(1'b1, 2 * FP, "enable_drop_rise");
        mark = cyc;
        DAC_VALUE = DW'($urandom);
        adc_q.push_back(16'h0ABC);
        wait_cs(1'b0, 2 * FP, "enable_drop_fall");
        repeat (20) @(negedge CLK);
        ENABLE = 1'b0;
        repeat (FP + 40) @(negedge CLK);
        s = find_fall(mark);
        later = (s < 0) ? -2 : find_fall(s + 1);
        total++; if (obs_vec(s, 0) !== model_cs()) begin bad++; $display("FAIL drop_cs_n: got %h expected %h", obs_vec(s, 0), model_cs()); end
        total++; if (obs_vec(s, 2) !== model_valid()) begin bad++; $display("FAIL drop_valid: got %h expected %h", obs_vec(s, 2), model_valid()); end
        total++; if (obs_adc(s) !== model_adc(16'h0ABC)) begin bad++; $display("FAIL drop_adc_value: got %h expected %h", obs_adc(s), model_adc(16'h0ABC)); end
        total++; if (later !== -1) begin bad++; $display("FAIL drop_no_new_frame: got fall at %0d expected none", later); end
        total++; if (CS_N !== 1'b1) begin bad++; $display("FAIL drop_idle_cs_n: got %b expected 1", CS_N); end
        ENABLE = 1'b1;
        @(negedge CLK);
        total++; if (CS_N !== 1'b0) begin bad++; $display("FAIL reenable_cs_fall: got %b expected 0", CS_N); end
    endtask

    task automatic test_reset_mid_frame();
        int rmark, s, stray;
        logic [FB-1:0] w;
        logic [DW-1:0] d;
        wait_cs(1'b1, 2 * FP, "reset_rise");
        wait_cs(1'b0, 2 * FP, "reset_fall");
        repeat (30) @(negedge CLK);
        total++; if (SCLK !== 1'b0) begin bad++; $display("FAIL pre_reset_sclk: got %b expected 0", SCLK); end
        rmark = cyc;
        RESET = 1'b1;
        #1;
        total++; if (CS_N !== 1'b1) begin bad++; $display("FAIL async_reset_cs_n: got %b expected 1", CS_N); end
        total++; if (SCLK !== 1'b1) begin bad++; $display("FAIL async_reset_sclk: got %b expected 1", SCLK); end
        total++; if (ADC_VALUE !== '0) begin bad++; $display("FAIL async_reset_adc_value: got %h expected 000", ADC_VALUE); end
        repeat (3) @(negedge CLK);
        w = FB'($urandom);
        d = DW'($urandom);
        adc_q.delete();
        adc_q.push_back(w);
        DAC_VALUE = d;
        RESET = 1'b0;
        repeat (FP + 4) @(negedge CLK);
        s = find_fall(rmark);
        stray = 0;
        if (s > 0)
            for (int c = rmark; c < s + VALID_N && c < TRACE_LEN; c++)
                if (vld_tr[c] !== 1'b0) stray++;
        total++; if (s < 0 || stray !== 0) begin bad++; $display("FAIL reset_no_valid: got %0d strobes (fall %0d) expected 0", stray, s); end
        total++; if (obs_vec(s, 2) !== model_valid()) begin bad++; $display("FAIL reset_first_valid: got %h expected %h", obs_vec(s, 2), model_valid()); end
        total++; if (obs_adc(s) !== model_adc(w)) begin bad++; $display("FAIL reset_adc_value: got %h expected %h", obs_adc(s), model_adc(w)); end
        total++; if (obs_dac(s) !== model_dac_bits(d)) begin bad++; $display("FAIL reset_dac_bits: got %h expected %h", obs_dac(s), model_dac_bits(d)); end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_back_to_back();
        test_dac_change();
        test_enable_drop();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
